sync_debounce: RTL and testbench



---
 rtl/sync_debounce.sv | 187 ++++++++++++++++++
 tb/tb_sync_debounce.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
//
// Input conditioning for a raw asynchronous level (push-button, switch,
// external strobe). The level is synchronised into the clk domain through a
// plain flop chain and then debounced: a new level must be seen on the
// synchronised signal for DEBOUNCE_CYCLES consecutive rising edges before it
// is accepted onto dout. Optional one-cycle rise/fall pulses are provided
// for edge-triggered consumers.
//
// Optional feature macro: SYNC_DEBOUNCE_EDGE_EN
//   defined   : rise/fall pulse flops are built.
//   undefined : rise and fall are tied to 0; dout/dout_b timing is unchanged.
//
// Parameters
//   SYNC_STAGES     : synchroniser flops (>= 2).
//   DEBOUNCE_CYCLES : consecutive edges a new level must hold (>= 1).
//   CNT_W           : counter width, DEBOUNCE_CYCLES <= 2**CNT_W - 1.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active low (0 = reset)
//   din       in   raw asynchronous level
//   dout      out  debounced, synchronised level (registered)
//   dout_b    out  always ~dout
//   rise      out  one-cycle pulse after dout goes 0->1 (registered)
//   fall      out  one-cycle pulse after dout goes 1->0 (registered)
//   state_dbg out  current debounce FSM state, for observation only
//
// Handshake: none. din is a free-running level; every output is a level or
// a single-cycle pulse valid for the whole cycle after the edge that set it.
// -----------------------------------------------------------------------------
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       dout,
  output logic       dout_b,
  output logic       rise,
  output logic       fall,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DC_C  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // Synchroniser: straight shift chain, only sync_q[0] may go metastable.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             dout_q, dout_nxt;

  assign cnt_inc = cnt + ONE_C;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= STABLE_LO;
      cnt    <= '0;
      dout_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dout_q <= dout_nxt;
    end
  end

  // The edge that leaves a stable state is already the first qualifying edge,
  // so with DEBOUNCE_CYCLES = 1 the wait state is skipped entirely. Inside a
  // wait state the counter holds the number of qualifying edges seen so far;
  // acceptance happens when the increment would reach DEBOUNCE_CYCLES, so the
  // counter never exceeds DEBOUNCE_CYCLES - 1 and cannot wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      STABLE_LO: begin
        if (s) begin
          if (DC_C <= ONE_C) begin
            state_nxt = STABLE_HI;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WAIT_HI;
            cnt_nxt   = ONE_C;
          end
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else if (cnt_inc >= DC_C) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          if (DC_C <= ONE_C) begin
            state_nxt = STABLE_LO;
            cnt_nxt   = '0;
          end else begin
            state_nxt = WAIT_LO;
            cnt_nxt   = ONE_C;
          end
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_nxt = STABLE_HI;
          cnt_nxt   = '0;
        end else if (cnt_inc >= DC_C) begin
          state_nxt = STABLE_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = STABLE_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // dout is high in STABLE_HI and WAIT_LO; registered alongside the state.
  assign dout_nxt = (state_nxt == STABLE_HI) || (state_nxt == WAIT_LO);

  assign dout      = dout_q;
  assign dout_b    = ~dout_q;
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Edge pulses: set on the same edge that changes dout, so each pulse is
  // high for exactly the cycle following the accepting edge.
  // ---------------------------------------------------------------------------
`ifdef SYNC_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= dout_nxt & ~dout_q;
      fall_q <= ~dout_nxt & dout_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// -----------------------------------------------------------------------------
// tb_sync_debounce
//
// Directed bench for sync_debounce. Instance a uses SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4; instance b uses SYNC_STAGES=2, DEBOUNCE_CYCLES=1.
// Inputs are driven 1 time unit after a rising edge, outputs sampled at the
// same point, so "edge e" below is the e-th rising edge after the drive.
// Expected pulse values follow SYNC_DEBOUNCE_EDGE_EN: with the macro
// undefined rise/fall must stay 0 while dout timing is unchanged.
// -----------------------------------------------------------------------------
module tb_sync_debounce;

`ifdef SYNC_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, din_a, dout_a, dout_b_a, rise_a, fall_a;
  logic [1:0] st_a;
  logic       rst_b, din_b, dout_b1, doutb_b1, rise_b, fall_b;
  logic [1:0] st_b;

  sync_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(16)) u_a (
    .clk      (clk),
    .rst      (rst_a),
    .din      (din_a),
    .dout     (dout_a),
    .dout_b   (dout_b_a),
    .rise     (rise_a),
    .fall     (fall_a),
    .state_dbg(st_a)
  );

  sync_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_W(4)) u_b (
    .clk      (clk),
    .rst      (rst_b),
    .din      (din_b),
    .dout     (dout_b1),
    .dout_b   (doutb_b1),
    .rise     (rise_b),
    .fall     (fall_b),
    .state_dbg(st_b)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and helpers
  // ---------------------------------------------------------------------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic exp_dout,
                       input logic exp_rise, input logic exp_fall);
    chk({tag, ".dout"},   dout_a,   exp_dout);
    chk({tag, ".dout_b"}, dout_b_a, ~exp_dout);
    chk({tag, ".rise"},   rise_a,   exp_rise & EDGE_EN);
    chk({tag, ".fall"},   fall_a,   exp_fall & EDGE_EN);
  endtask

  task automatic chk_b(input string tag, input logic exp_dout,
                       input logic exp_rise, input logic exp_fall);
    chk({tag, ".dout"},   dout_b1,  exp_dout);
    chk({tag, ".dout_b"}, doutb_b1, ~exp_dout);
    chk({tag, ".rise"},   rise_b,   exp_rise & EDGE_EN);
    chk({tag, ".fall"},   fall_b,   exp_fall & EDGE_EN);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic lvl;
    rst_a = 1'b0; din_a = 1'b0;
    rst_b = 1'b0; din_b = 1'b0;

    // Reset values: din toggles while reset held, outputs stay at reset.
    for (int i = 0; i < 8; i++) begin
      din_a = $urandom_range(0, 1);
      din_b = $urandom_range(0, 1);
      step(1);
      chk_a($sformatf("rst_hold_a%0d", i), 1'b0, 1'b0, 1'b0);
      chk_b($sformatf("rst_hold_b%0d", i), 1'b0, 1'b0, 1'b0);
    end
    din_a = 1'b0; din_b = 1'b0;
    step(1);
    rst_a = 1'b1; rst_b = 1'b1;
    step(3);
    chk_a("idle_a", 1'b0, 1'b0, 1'b0);

    // Clean rise: accepted at edge 2 + 4 = 6.
    din_a = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      chk_a($sformatf("rise_e%0d", e), (e >= 6), (e == 6), 1'b0);
    end
    step(1);
    chk_a("rise_e7", 1'b1, 1'b0, 1'b0);
    step(2);

    // Clean fall.
    din_a = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      chk_a($sformatf("fall_e%0d", e), (e < 6), 1'b0, (e == 6));
    end
    step(1);
    chk_a("fall_e7", 1'b0, 1'b0, 1'b0);
    step(2);

    // Glitch rejection: 3 edges high is discarded.
    din_a = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step(1);
      if (e == 3) din_a = 1'b0;
      chk_a($sformatf("glitch_e%0d", e), 1'b0, 1'b0, 1'b0);
    end

    // A 4-edge pulse is accepted at edge 6 of that pulse.
    din_a = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      if (e == 4) din_a = 1'b0;
      chk_a($sformatf("pulse4_e%0d", e), (e >= 6), (e == 6), 1'b0);
    end
    step(1);
    chk_a("pulse4_e7", 1'b1, 1'b0, 1'b0);
    // din has been low since edge 4: fall lands at edge 4 + 6 = 10.
    step(3);
    chk_a("pulse4_e10", 1'b0, 1'b0, 1'b1);
    step(1);
    chk_a("pulse4_e11", 1'b0, 1'b0, 1'b0);
    step(2);

    // Reset mid-wait: pending acceptance abandoned.
    din_a = 1'b1;
    step(4);
    chk_a("midwait_pre", 1'b0, 1'b0, 1'b0);
    #2 rst_a = 1'b0;
    #1 chk_a("midwait_rst", 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      step(1);
      chk_a($sformatf("midwait_hold%0d", e), 1'b0, 1'b0, 1'b0);
    end
    rst_a = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step(1);
      chk_a($sformatf("midwait_rel_e%0d", e), (e >= 6), (e == 6), 1'b0);
    end

    // Asynchronous reset while dout=1 and rise pending: outputs drop at once.
    #3 rst_a = 1'b0;
    #1 chk_a("async_rst", 1'b0, 1'b0, 1'b0);
    din_a = 1'b0;
    step(1);
    rst_a = 1'b1;
    step(8);
    chk_a("async_after", 1'b0, 1'b0, 1'b0);

    // DEBOUNCE_CYCLES=1: toggle every 3 cycles, accepted at edge 3 each time.
    lvl = 1'b0;
    for (int t = 0; t < 6; t++) begin
      lvl   = ~lvl;
      din_b = lvl;
      for (int e = 1; e <= 3; e++) begin
        step(1);
        chk_b($sformatf("dc1_t%0d_e%0d", t, e),
              (e >= 3) ? lvl : ~lvl,
              (e == 3) && lvl,
              (e == 3) && !lvl);
      end
    end
    step(1);
    chk_b("dc1_tail", lvl, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
